// File: rtl/reg_file_sb.sv
// Register file with two registered read ports, one write port and a per-register busy scoreboard.
// Optional same-cycle write/reserve visibility on reads: define REGFILE_WRITE_BYPASS_EN.
module reg_file_sb #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int ZERO_R0 = 0
) (
    input  logic              I_CLK,
    input  logic              I_RST_N,
    input  logic              I_EN,
    input  logic              I_WE,
    input  logic [ADDR_W-1:0] I_SELD,
    input  logic [DATA_W-1:0] I_DATAD,
    input  logic              I_RSV,
    input  logic [ADDR_W-1:0] I_SELR,
    input  logic [ADDR_W-1:0] I_SELA,
    input  logic [ADDR_W-1:0] I_SELB,
    output logic [DATA_W-1:0] O_DATAA,
    output logic [DATA_W-1:0] O_DATAB,
    output logic              O_BUSYA,
    output logic              O_BUSYB
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic              wr_ok;
    logic              rsv_ok;

    logic [DATA_W-1:0] data_a_p1;
    logic [DATA_W-1:0] data_b_p1;
    logic              busy_a_p1;
    logic              busy_b_p1;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] sel);
        return (ZERO_R0 != 0) && (sel == '0);
    endfunction

    assign wr_ok  = I_WE  && !is_zero_reg(I_SELD);
    assign rsv_ok = I_RSV && !is_zero_reg(I_SELR);

    // Reserve is applied after the write clear so a same-cycle reservation wins.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok)
            busy_nxt[I_SELD] = 1'b0;
        if (rsv_ok)
            busy_nxt[I_SELR] = 1'b1;
    end

    function automatic logic [DATA_W-1:0] read_data(input logic [ADDR_W-1:0] sel);
        logic [DATA_W-1:0] d;
        d = regs[sel];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (wr_ok && (sel == I_SELD))
            d = I_DATAD;
`endif
        if (is_zero_reg(sel))
            d = '0;
        return d;
    endfunction

    function automatic logic read_busy(input logic [ADDR_W-1:0] sel);
        logic b;
`ifdef REGFILE_WRITE_BYPASS_EN
        b = busy_nxt[sel];
`else
        b = busy[sel];
`endif
        if (is_zero_reg(sel))
            b = 1'b0;
        return b;
    endfunction

    // Stage p1: array update and registered read ports
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            busy      <= '0;
            data_a_p1 <= '0;
            data_b_p1 <= '0;
            busy_a_p1 <= 1'b0;
            busy_b_p1 <= 1'b0;
        end else if (I_EN) begin
            if (wr_ok)
                regs[I_SELD] <= I_DATAD;
            busy      <= busy_nxt;
            data_a_p1 <= read_data(I_SELA);
            data_b_p1 <= read_data(I_SELB);
            busy_a_p1 <= read_busy(I_SELA);
            busy_b_p1 <= read_busy(I_SELB);
        end
    end

    assign O_DATAA = data_a_p1;
    assign O_DATAB = data_b_p1;
    assign O_BUSYA = busy_a_p1;
    assign O_BUSYB = busy_b_p1;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb: default, ZERO_R0=1 and 32x16 instances.
module tb_reg_file_sb;

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1, we = 1'b0, rsv = 1'b0;
    logic [2:0]  seld = '0, selr = '0, sela = '0, selb = '0;
    logic [15:0] datad = '0;
    logic [15:0] da, db, za, zb;
    logic        ba, bb, zba, zbb;

    logic        w_we = 1'b0;
    logic [3:0]  w_seld = '0, w_sela = '0, w_selb = '0;
    logic [31:0] w_datad = '0;
    logic [31:0] w_da, w_db;
    logic        w_ba, w_bb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_sb dut (
        .I_CLK(clk), .I_RST_N(rst_n), .I_EN(en), .I_WE(we), .I_SELD(seld), .I_DATAD(datad),
        .I_RSV(rsv), .I_SELR(selr), .I_SELA(sela), .I_SELB(selb),
        .O_DATAA(da), .O_DATAB(db), .O_BUSYA(ba), .O_BUSYB(bb)
    );

    reg_file_sb #(.ZERO_R0(1)) dut_z (
        .I_CLK(clk), .I_RST_N(rst_n), .I_EN(en), .I_WE(we), .I_SELD(seld), .I_DATAD(datad),
        .I_RSV(rsv), .I_SELR(selr), .I_SELA(sela), .I_SELB(selb),
        .O_DATAA(za), .O_DATAB(zb), .O_BUSYA(zba), .O_BUSYB(zbb)
    );

    reg_file_sb #(.DATA_W(32), .ADDR_W(4)) dut_w (
        .I_CLK(clk), .I_RST_N(rst_n), .I_EN(1'b1), .I_WE(w_we), .I_SELD(w_seld), .I_DATAD(w_datad),
        .I_RSV(1'b0), .I_SELR(4'd0), .I_SELA(w_sela), .I_SELB(w_selb),
        .O_DATAA(w_da), .O_DATAB(w_db), .O_BUSYA(w_ba), .O_BUSYB(w_bb)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; rsv = 1'b0; en = 1'b1;
    endtask

    task automatic test_reset();
        cyc();
        checks++; if (da !== 16'h0 || db !== 16'h0) begin errors++; $display("FAIL reset_hold_data: got %h/%h want 0000/0000", da, db); end
        checks++; if (ba !== 1'b0 || bb !== 1'b0) begin errors++; $display("FAIL reset_hold_busy: got %b/%b want 0/0", ba, bb); end
        rst_n = 1'b1;
        we = 1'b1; seld = 3'd3; datad = 16'hBEEF; rsv = 1'b1; selr = 3'd3;
        cyc();
        idle(); sela = 3'd3; selb = 3'd3;
        cyc();
        checks++; if (da !== 16'hBEEF || ba !== 1'b1) begin errors++; $display("FAIL pre_reset_r3: got %h busy %b want BEEF busy 1", da, ba); end
        rst_n = 1'b0;
        #1;
        checks++; if (da !== 16'h0 || db !== 16'h0 || ba !== 1'b0 || bb !== 1'b0) begin
            errors++; $display("FAIL async_reset: got %h/%h %b/%b want all 0", da, db, ba, bb); end
        cyc();
        checks++; if (da !== 16'h0 || ba !== 1'b0) begin errors++; $display("FAIL reset_held_edge: got %h %b want 0000 0", da, ba); end
        rst_n = 1'b1;
        cyc();
        checks++; if (da !== 16'h0 || ba !== 1'b0) begin errors++; $display("FAIL post_reset_r3: got %h busy %b want 0000 busy 0", da, ba); end
    endtask

    task automatic test_write_read();
        we = 1'b1; seld = 3'd5; datad = 16'h1234;
        cyc();
        seld = 3'd2; datad = 16'hA5A5;
        cyc();
        idle(); sela = 3'd5; selb = 3'd2;
        cyc();
        checks++; if (da !== 16'h1234 || db !== 16'hA5A5) begin errors++; $display("FAIL write_read: got %h/%h want 1234/A5A5", da, db); end
        en = 1'b0; we = 1'b1; seld = 3'd5; datad = 16'hFFFF; rsv = 1'b1; selr = 3'd2; sela = 3'd2; selb = 3'd5;
        cyc();
        checks++; if (da !== 16'h1234 || db !== 16'hA5A5) begin errors++; $display("FAIL en_low_hold: got %h/%h want 1234/A5A5", da, db); end
        idle();
        cyc();
        checks++; if (da !== 16'hA5A5 || db !== 16'h1234 || ba !== 1'b0) begin
            errors++; $display("FAIL en_low_retain: got %h/%h busy %b want A5A5/1234 busy 0", da, db, ba); end
    endtask

    task automatic test_collision();
        we = 1'b1; seld = 3'd4; datad = 16'h0011;
        cyc();
        datad = 16'h00FF; sela = 3'd4; selb = 3'd4;
        cyc();
        checks++; if (da !== (BYP ? 16'h00FF : 16'h0011)) begin
            errors++; $display("FAIL collision_same_cycle: got %h want %h", da, BYP ? 16'h00FF : 16'h0011); end
        idle();
        cyc();
        checks++; if (da !== 16'h00FF || db !== 16'h00FF) begin errors++; $display("FAIL collision_next: got %h/%h want 00FF/00FF", da, db); end
    endtask

    task automatic test_scoreboard();
        rsv = 1'b1; selr = 3'd6; sela = 3'd0; selb = 3'd0;
        cyc();
        idle(); sela = 3'd6; selb = 3'd6;
        cyc();
        checks++; if (ba !== 1'b1 || bb !== 1'b1) begin errors++; $display("FAIL reserve_busy: got %b/%b want 1/1", ba, bb); end
        rsv = 1'b1;
        cyc();
        idle();
        cyc();
        checks++; if (ba !== 1'b1) begin errors++; $display("FAIL re_reserve: got %b want 1", ba); end
        we = 1'b1; seld = 3'd6; datad = 16'h7777; sela = 3'd1; selb = 3'd1;
        cyc();
        idle(); sela = 3'd6;
        cyc();
        checks++; if (ba !== 1'b0 || da !== 16'h7777) begin errors++; $display("FAIL write_clears: got %h busy %b want 7777 busy 0", da, ba); end
        we = 1'b1; seld = 3'd6; datad = 16'h1111; rsv = 1'b1; selr = 3'd6; sela = 3'd7; selb = 3'd7;
        cyc();
        idle(); sela = 3'd6; selb = 3'd6;
        cyc();
        checks++; if (ba !== 1'b1 || bb !== 1'b1 || da !== 16'h1111 || db !== 16'h1111) begin
            errors++; $display("FAIL rsv_write_same: got %h/%h busy %b/%b want 1111/1111 busy 1/1", da, db, ba, bb); end
        rsv = 1'b1; selr = 3'd1; sela = 3'd1; selb = 3'd6;
        cyc();
        checks++; if (ba !== BYP || bb !== 1'b1) begin errors++; $display("FAIL rsv_bypass: got %b/%b want %b/1", ba, bb, BYP); end
        idle();
        cyc();
        checks++; if (ba !== 1'b1) begin errors++; $display("FAIL rsv_next: got %b want 1", ba); end
        we = 1'b1; seld = 3'd3; datad = 16'h0042; sela = 3'd3; selb = 3'd3;
        cyc();
        checks++; if (da !== (BYP ? 16'h0042 : 16'h0000) || ba !== 1'b0) begin
            errors++; $display("FAIL write_nonbusy: got %h busy %b want %h busy 0", da, ba, BYP ? 16'h0042 : 16'h0000); end
        idle();
    endtask

    task automatic test_zero_r0();
        we = 1'b1; seld = 3'd0; datad = 16'hFFFF; rsv = 1'b1; selr = 3'd0; sela = 3'd0; selb = 3'd0;
        cyc();
        idle();
        cyc();
        checks++; if (za !== 16'h0 || zb !== 16'h0 || zba !== 1'b0 || zbb !== 1'b0) begin
            errors++; $display("FAIL zero_r0: got %h/%h busy %b/%b want 0000/0000 busy 0/0", za, zb, zba, zbb); end
        checks++; if (da !== 16'hFFFF || ba !== 1'b1) begin errors++; $display("FAIL normal_r0: got %h busy %b want FFFF busy 1", da, ba); end
        sela = 3'd5; selb = 3'd2;
        cyc();
        checks++; if (za !== 16'h1234 || zb !== 16'hA5A5) begin errors++; $display("FAIL zero_inst_r5: got %h/%h want 1234/A5A5", za, zb); end
    endtask

    task automatic test_wide();
        w_we = 1'b1; w_seld = 4'd7; w_datad = 32'h12345678;
        cyc();
        w_seld = 4'd15; w_datad = 32'hDEADBEEF;
        cyc();
        w_we = 1'b0; w_sela = 4'd15; w_selb = 4'd7;
        cyc();
        checks++; if (w_da !== 32'hDEADBEEF || w_db !== 32'h12345678) begin
            errors++; $display("FAIL wide_readback: got %h/%h want DEADBEEF/12345678", w_da, w_db); end
        checks++; if (w_ba !== 1'b0 || w_bb !== 1'b0) begin errors++; $display("FAIL wide_busy: got %b/%b want 0/0", w_ba, w_bb); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_scoreboard();
        test_zero_r0();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
